// File: rtl/encoder_pos_counter.sv
// encoder_pos_counter: quadrature decoder producing a signed, wrapping position
// count in x1/x2/x4 resolution, with illegal-transition detection and index
// (Z) capture.
// Optional feature macro: INDEX_CLEAR_EN -- when defined, a Z rising edge also
// zeroes the position after capturing it into indexPos.
module encoder_pos_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             phaseA,
    input  logic             phaseB,
    input  logic             phaseZ,
    input  logic [2:0]       cntSetting,
    input  logic             loadEn,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             errClear,
    output logic [WIDTH-1:0] position,
    output logic             countValid,
    output logic [WIDTH-1:0] indexPos,
    output logic             indexPulse,
    output logic             errorFlag
);

    typedef enum logic [1:0] {
        MODE_X1  = 2'd0,
        MODE_X2  = 2'd1,
        MODE_X4  = 2'd2,
        MODE_OFF = 2'd3
    } mode_e;

    // Phase vectors are packed as {Z, A, B}.
    logic [2:0] r_meta;
    logic [2:0] r_sync;
    logic [2:0] r_prev;
    logic [1:0] r_prime;

    mode_e w_mode;
    logic  w_primed;
    logic  w_a_prev, w_b_prev, w_a_cur, w_b_cur;
    logic  w_a_chg, w_b_chg;
    logic  w_illegal;
    logic  w_step_up, w_step_dn;
    logic  w_z_rise;

    // Two-flop synchroniser followed by the history register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its source, forming a real pipeline.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= {phaseZ, phaseA, phaseB};
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Prime counter: suppress all decoding until the pipeline holds real pin data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prime <= '0;
        end else if (r_prime != 2'd3) begin
            r_prime <= r_prime + 2'd1;
        end
    end

    assign w_primed  = (r_prime == 2'd3);
    assign w_a_prev  = r_prev[1];
    assign w_b_prev  = r_prev[0];
    assign w_a_cur   = r_sync[1];
    assign w_b_cur   = r_sync[0];
    assign w_a_chg   = w_a_prev ^ w_a_cur;
    assign w_b_chg   = w_b_prev ^ w_b_cur;
    assign w_illegal = w_primed & w_a_chg & w_b_chg;
    assign w_z_rise  = w_primed & r_sync[2] & ~r_prev[2];

    // Resolution select; every unused encoding disables counting.
    always_comb begin
        case (cntSetting)
            3'd0:    w_mode = MODE_X1;
            3'd1:    w_mode = MODE_X2;
            3'd2:    w_mode = MODE_X4;
            default: w_mode = MODE_OFF;
        endcase
    end

    // Step decode. After an A edge the direction is up when A and B differ;
    // after a B edge it is up when they are equal (forward order 00,10,11,01).
    // NOTE: both outputs get a default before any branch so no latch is inferred.
    always_comb begin
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        if (w_primed && !(w_a_chg && w_b_chg)) begin
            case (w_mode)
                MODE_X4: begin
                    if (w_a_chg) begin
                        w_step_up = w_a_cur ^ w_b_cur;
                        w_step_dn = ~(w_a_cur ^ w_b_cur);
                    end else if (w_b_chg) begin
                        w_step_up = ~(w_a_cur ^ w_b_cur);
                        w_step_dn = w_a_cur ^ w_b_cur;
                    end
                end
                MODE_X2: begin
                    if (w_a_chg) begin
                        w_step_up = w_a_cur ^ w_b_cur;
                        w_step_dn = ~(w_a_cur ^ w_b_cur);
                    end
                end
                MODE_X1: begin
                    if (w_a_chg && w_a_cur) begin
                        w_step_up = ~w_b_cur;
                        w_step_dn = w_b_cur;
                    end
                end
                default: begin
                    w_step_up = 1'b0;
                    w_step_dn = 1'b0;
                end
            endcase
        end
    end

    // Position register: load beats index clear (when built in) beats counting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            position   <= '0;
            countValid <= 1'b0;
        end else if (loadEn) begin
            position   <= loadValue;
            countValid <= 1'b0;
`ifdef INDEX_CLEAR_EN
        end else if (w_z_rise) begin
            position   <= '0;
            countValid <= 1'b0;
`endif
        end else if (w_step_up) begin
            position   <= position + WIDTH'(1);
            countValid <= 1'b1;
        end else if (w_step_dn) begin
            position   <= position - WIDTH'(1);
            countValid <= 1'b1;
        end else begin
            countValid <= 1'b0;
        end
    end

    // Index capture takes the position as it stood before this edge's update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            indexPos   <= '0;
            indexPulse <= 1'b0;
        end else begin
            indexPulse <= w_z_rise;
            if (w_z_rise) begin
                indexPos <= position;
            end
        end
    end

    // Sticky error flag; a new illegal transition wins over a same-cycle clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            errorFlag <= 1'b0;
        end else if (w_illegal) begin
            errorFlag <= 1'b1;
        end else if (errClear) begin
            errorFlag <= 1'b0;
        end
    end

endmodule
